// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  // Fetch addresses are word aligned; the low two bits are dropped.
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: power-of-two FIFO holding {pc, inst} entries, with a
// synchronous flush that empties it in one edge. Storage is not reset.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 96,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_en;
  logic             push_en;

  // Guard both ends so the count can never leave [0, DEPTH].
  assign pop_en  = pop && (count_q != '0);
  assign push_en = push && ((count_q < DEPTH_C) || pop_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: PC + IDLE/RUN/HALT FSM feeding a fetch FIFO.
// Define FETCH_HALT_EN to stop fetching after an ebreak is pushed.
module inst_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        rom_ce,
  output logic [63:0] rom_addr,
  input  logic [31:0] rom_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        halted
);

  localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [CNT_W-1:0] fifo_count;
  logic [95:0]      head_data;
  logic             pop;
  logic             push_ok;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts a push when the head leaves in the same edge.
  assign push_ok   = (fifo_count < DEPTH_C) || ((fifo_count == DEPTH_C) && pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    rom_ce  = 1'b0;
    if (redirect_valid) begin
      state_d = ST_RUN;
      pc_d    = align_pc(redirect_pc);
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          rom_ce = push_ok;
          if (push_ok) begin
            pc_d = pc_q + 64'd4;
`ifdef FETCH_HALT_EN
            if (rom_inst == EBREAK_INST) begin
              state_d = ST_HALT;
            end
`endif
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (96)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (rom_ce),
    .pop       (pop),
    .push_data ({pc_q, rom_inst}),
    .count     (fifo_count),
    .head_data (head_data)
  );

  assign rom_addr = pc_q;
  assign out_pc   = out_valid ? head_data[95:32] : 64'd0;
  assign out_inst = out_valid ? head_data[31:0]  : 32'd0;

`ifdef FETCH_HALT_EN
  assign halted = (state_q == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed self-checking bench for inst_fetch_ctrl with a combinational ROM model.
module tb_inst_fetch_ctrl;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        rom_ce;
  logic [63:0] rom_addr;
  logic [31:0] rom_inst;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        halted;
  logic [63:0] ebreak_addr = 64'h1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_F00F;
  endfunction

  assign rom_inst = (rom_addr == ebreak_addr) ? EBREAK : inst_of(rom_addr);

  inst_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic rv, input logic [63:0] rpc);
    @(negedge clk);
    rst            = r;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  initial begin
    // Reset values
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_rom_ce", rom_ce, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_halted", halted, 0);

    // Reset release, ready high
    step(0, 1, 0, 0);
    chk("idle_rom_ce", rom_ce, 0);
    chk("idle_valid", out_valid, 0);
    chk("idle_addr", rom_addr, 64'h8000_0000);
    step(0, 1, 0, 0);
    chk("run_rom_ce", rom_ce, 1);
    chk("run_addr", rom_addr, 64'h8000_0000);
    chk("run_valid", out_valid, 0);
    step(0, 1, 0, 0);
    chk("tp_valid0", out_valid, 1);
    chk("tp_pc0", out_pc, 64'h8000_0000);
    chk("tp_inst0", out_inst, inst_of(64'h8000_0000));
    step(0, 1, 0, 0);
    chk("tp_pc1", out_pc, 64'h8000_0004);
    step(0, 1, 0, 0);
    chk("tp_pc2", out_pc, 64'h8000_0008);
    chk("tp_addr", rom_addr, 64'h8000_000C);

    // Back-pressure from reset
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("bp_a_ce", rom_ce, 0);
    step(0, 0, 0, 0);
    chk("bp_b_ce", rom_ce, 1);
    chk("bp_b_addr", rom_addr, 64'h8000_0000);
    step(0, 0, 0, 0);
    chk("bp_c_ce", rom_ce, 1);
    chk("bp_c_addr", rom_addr, 64'h8000_0004);
    step(0, 0, 0, 0);
    chk("bp_d_ce", rom_ce, 0);
    chk("bp_d_addr", rom_addr, 64'h8000_0008);
    chk("bp_d_pc", out_pc, 64'h8000_0000);
    step(0, 0, 0, 0);
    chk("bp_e_ce", rom_ce, 0);
    chk("bp_e_addr", rom_addr, 64'h8000_0008);
    step(0, 1, 0, 0);
    chk("bp_f_ce", rom_ce, 1);
    chk("bp_f_pc", out_pc, 64'h8000_0000);
    step(0, 1, 0, 0);
    chk("bp_g_pc", out_pc, 64'h8000_0004);
    chk("bp_g_addr", rom_addr, 64'h8000_000C);
    step(0, 1, 0, 0);
    chk("bp_h_pc", out_pc, 64'h8000_0008);
    chk("bp_h_inst", out_inst, inst_of(64'h8000_0008));

    // Redirect while full, unaligned target
    step(0, 1, 1, 64'h0000_0000_0000_0103);
    chk("rd_ce", rom_ce, 0);
    step(0, 1, 0, 0);
    chk("rd_valid", out_valid, 0);
    chk("rd_out_pc", out_pc, 0);
    chk("rd_addr", rom_addr, 64'h100);
    chk("rd_ce2", rom_ce, 1);
    step(0, 1, 0, 0);
    chk("rd_pc", out_pc, 64'h100);
    chk("rd_inst", out_inst, inst_of(64'h100));

    // PC wrap
    step(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, 1, 0, 0);
    chk("wr_addr", rom_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_valid", out_valid, 0);
    step(0, 1, 0, 0);
    chk("wr_pc0", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wr_addr0", rom_addr, 64'h0);
    step(0, 1, 0, 0);
    chk("wr_pc1", out_pc, 64'h0);
    chk("wr_inst1", out_inst, inst_of(64'h0));

    // Fill two entries, then reset together with redirect
    step(0, 0, 0, 0);
    chk("fl_pc", out_pc, 64'h4);
    step(0, 0, 0, 0);
    chk("fl_valid", out_valid, 1);
    chk("fl_ce", rom_ce, 0);
    chk("fl_addr", rom_addr, 64'hC);
    step(1, 0, 1, 64'h200);
    ebreak_addr = 64'h8000_0008;
    step(0, 1, 0, 0);
    chk("rr_valid", out_valid, 0);
    chk("rr_addr", rom_addr, 64'h8000_0000);
    chk("rr_ce", rom_ce, 0);
    chk("rr_pc", out_pc, 0);

    // ebreak at 8000_0008
    step(0, 1, 0, 0);
    chk("eb_t_ce", rom_ce, 1);
    step(0, 1, 0, 0);
    chk("eb_u_pc", out_pc, 64'h8000_0000);
    step(0, 1, 0, 0);
    chk("eb_v_pc", out_pc, 64'h8000_0004);
    chk("eb_v_ce", rom_ce, 1);
    chk("eb_v_halted", halted, 0);
    step(0, 1, 0, 0);
    chk("eb_w_pc", out_pc, 64'h8000_0008);
    chk("eb_w_inst", out_inst, {32'd0, EBREAK});
    chk("eb_w_addr", rom_addr, 64'h8000_000C);
`ifdef FETCH_HALT_EN
    chk("eb_w_halted", halted, 1);
    chk("eb_w_ce", rom_ce, 0);
    step(0, 1, 0, 0);
    chk("eb_x_valid", out_valid, 0);
    chk("eb_x_halted", halted, 1);
    chk("eb_x_ce", rom_ce, 0);
    step(0, 1, 1, 64'h8000_0000);
    chk("eb_y_halted", halted, 1);
    chk("eb_y_ce", rom_ce, 0);
`else
    chk("eb_w_halted", halted, 0);
    chk("eb_w_ce", rom_ce, 1);
    step(0, 1, 0, 0);
    chk("eb_x_pc", out_pc, 64'h8000_000C);
    chk("eb_x_halted", halted, 0);
    step(0, 1, 1, 64'h8000_0000);
    chk("eb_y_halted", halted, 0);
`endif
    step(0, 1, 0, 0);
    chk("eb_z_halted", halted, 0);
    chk("eb_z_ce", rom_ce, 1);
    chk("eb_z_addr", rom_addr, 64'h8000_0000);
    step(0, 1, 0, 0);
    chk("eb_aa_pc", out_pc, 64'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
